// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared register arbiter: FSM state encoding,
// default geometry and a helper to size requester index fields.
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_ACK   = 2'b10
  } state_t;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  // Width of an index able to address n requesters (never narrower than 1 bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr.sv
// Round-robin picker: returns the first set request bit found when searching
// upward from ptr and wrapping from N-1 back to 0. Purely combinational.
module rr_priority_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  logic [IW:0] sum_s;
  logic [IW:0] cand_s;
  logic        hit_s;

  // Scan from the farthest candidate back to ptr so the closest request wins last.
  always_comb begin
    found  = 1'b0;
    idx    = {IW{1'b0}};
    sum_s  = {(IW+1){1'b0}};
    cand_s = {(IW+1){1'b0}};
    hit_s  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      sum_s  = {1'b0, ptr} + (IW+1)'(k);
      cand_s = (sum_s >= N_EXT) ? (sum_s - N_EXT) : sum_s;
      hit_s  = req[cand_s[IW-1:0]];
      found  = found | hit_s;
      idx    = hit_s ? cand_s[IW-1:0] : idx;
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Shared register arbiter: N requesters compete round-robin for a single
// W-bit register. A transfer is IDLE (pick) -> GRANT (write if request still
// held) -> ACK (one-cycle done pulse, advance pointer past the winner).
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] WDATA,
  output logic [N-1:0]   GNT,
  output logic [N-1:0]   ACK,
  output logic [W-1:0]   Q,
  output logic           BUSY
);

  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t        state_r;
  state_t        state_nxt;
  logic [IW-1:0] ptr_r;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] idx_nxt;
  logic [N-1:0]  gnt_r;
  logic [N-1:0]  gnt_nxt;
  logic [N-1:0]  ack_r;
  logic [N-1:0]  ack_nxt;
  logic [W-1:0]  q_r;
  logic [W-1:0]  q_nxt;

  logic          pick_found_s;
  logic [IW-1:0] pick_idx_s;
  logic          req_held_s;
  logic [W-1:0]  wdata_sel_s;

  function automatic logic [N-1:0] one_hot(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v    = {N{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  rr_priority_pick #(.N(N)) u_pick (
    .req   (REQ),
    .ptr   (ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Only the latched winner's request and data matter once a grant is out.
  assign req_held_s  = REQ[idx_r];
  assign wdata_sel_s = WDATA[idx_r*W +: W];

  // FSM state register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic: pick, then write-or-abort, then always return to IDLE.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE:  state_nxt = pick_found_s ? ST_GRANT : ST_IDLE;
      ST_GRANT: state_nxt = req_held_s ? ST_ACK : ST_IDLE;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values: grant, done pulse, register load and pointer.
  always_comb begin
    ptr_nxt = ptr_r;
    idx_nxt = idx_r;
    gnt_nxt = gnt_r;
    ack_nxt = {N{1'b0}};
    q_nxt   = q_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          idx_nxt = pick_idx_s;
          gnt_nxt = one_hot(pick_idx_s);
        end else begin
          gnt_nxt = {N{1'b0}};
        end
      end
      ST_GRANT: begin
        if (req_held_s) begin
          q_nxt   = wdata_sel_s;
          ack_nxt = one_hot(idx_r);
        end else begin
          // Abort: winner withdrew, pointer stays so nobody loses their turn.
          gnt_nxt = {N{1'b0}};
        end
      end
      ST_ACK: begin
        gnt_nxt = {N{1'b0}};
        ptr_nxt = (idx_r == LAST_IDX) ? {IW{1'b0}} : (idx_r + IW'(1));
      end
      default: begin
        gnt_nxt = {N{1'b0}};
      end
    endcase
  end

  // Datapath registers; reset clears everything so no pulse survives a reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr_r <= {IW{1'b0}};
      idx_r <= {IW{1'b0}};
      gnt_r <= {N{1'b0}};
      ack_r <= {N{1'b0}};
      q_r   <= {W{1'b0}};
    end else begin
      ptr_r <= ptr_nxt;
      idx_r <= idx_nxt;
      gnt_r <= gnt_nxt;
      ack_r <= ack_nxt;
      q_r   <= q_nxt;
    end
  end

  assign GNT  = gnt_r;
  assign ACK  = ack_r;
  assign Q    = q_r;
  assign BUSY = (state_r != ST_IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios, random
// protocol-violating traffic and a well-behaved-requester phase, all checked
// cycle by cycle against a transfer-level reference model.
module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic           busy;

  int n_cmp;
  int n_mis;

  // Reference model: phase 0 = no transfer, 1 = granted, 2 = done pulse.
  int         m_phase;
  int         m_owner;
  int         m_ptr;
  logic [W-1:0] m_q;

  int order[5] = '{0, 1, 2, 3, 0};
  int wc[N];

  shared_reg_arbiter #(.N(N), .W(W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .REQ   (req),
    .WDATA (wdata),
    .GNT   (gnt),
    .ACK   (ack),
    .Q     (q),
    .BUSY  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    if (!rst_n) begin
      m_phase = 0;
      m_ptr   = 0;
      m_owner = 0;
      m_q     = '0;
    end else if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        if (req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_phase = 1;
          break;
        end
      end
    end else if (m_phase == 1) begin
      if (req[m_owner]) begin
        m_q     = wdata[m_owner*W +: W];
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end else begin
      m_phase = 0;
      m_ptr   = (m_owner + 1) % N;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] eg;
    logic [N-1:0] ea;
    @(posedge clk);
    model_step();
    #1;
    eg = '0;
    ea = '0;
    if (m_phase != 0) eg[m_owner] = 1'b1;
    if (m_phase == 2) ea[m_owner] = 1'b1;
    chk("gnt", gnt, eg);
    chk("ack", ack, ea);
    chk("q", q, m_q);
    chk("busy", busy, m_phase != 0);
  endtask

  task automatic set_slice(input int i, input logic [W-1:0] d);
    wdata[i*W +: W] = d;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    m_phase = 0; m_owner = 0; m_ptr = 0; m_q = '0;
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    for (int i = 0; i < N; i++) wc[i] = 0;

    repeat (2) cycle();
    chk("rst_gnt", gnt, 0);
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);

    // Single write with fixed latency.
    rst_n = 1'b1;
    req   = 4'b0001;
    set_slice(0, 8'hA5);
    cycle();
    chk("t28_gnt", gnt, 4'b0001);
    chk("t28_busy", busy, 1);
    cycle();
    chk("t28_q", q, 8'hA5);
    chk("t28_ack", ack, 4'b0001);
    req = '0;
    cycle();
    chk("t28_busy_off", busy, 0);
    chk("t28_ack_off", ack, 0);

    // All requesting: fair rotation 0,1,2,3,0.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    req   = 4'b1111;
    wdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    for (int t = 0; t < 5; t++) begin
      cycle();
      chk("t29_gnt", gnt, 1 << order[t]);
      cycle();
      chk("t29_ack", ack, 1 << order[t]);
      chk("t29_q", q, wdata[order[t]*W +: W]);
      cycle();
    end
    req = '0;
    cycle();

    // Pointer wrap after requester 3, then abort leaves Q and pointer alone.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    req = 4'b1000;
    set_slice(3, 8'h3C);
    cycle();
    cycle();
    chk("t32_q3", q, 8'h3C);
    req = '0;
    cycle();
    req = 4'b1001;
    set_slice(0, 8'h5A);
    cycle();
    chk("t32_gnt", gnt, 4'b0001);
    cycle();
    chk("t32_q0", q, 8'h5A);
    req = '0;
    cycle();
    req = 4'b1000;
    set_slice(3, 8'h77);
    cycle();
    cycle();
    req = '0;
    cycle();
    req = 4'b0100;
    set_slice(2, 8'hEE);
    cycle();
    chk("t30_gnt", gnt, 4'b0100);
    req = '0;
    cycle();
    chk("t30_gnt_off", gnt, 0);
    chk("t30_no_ack", ack, 0);
    chk("t30_q_kept", q, 8'h77);
    req = 4'b0110;
    set_slice(1, 8'h11);
    cycle();
    chk("t30_regrant", gnt, 4'b0010);

    // Reset in the middle of a grant kills the transfer.
    rst_n = 1'b0;
    req   = 4'b0010;
    cycle();
    chk("t31_gnt", gnt, 0);
    chk("t31_ack", ack, 0);
    chk("t31_q", q, 0);
    chk("t31_busy", busy, 0);
    rst_n = 1'b1;
    req   = '0;
    cycle();
    chk("t31_no_ack", ack, 0);
    cycle();

    // Random traffic including aborts and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      if ($urandom_range(0, 3) == 0) wdata = (N*W)'($urandom);
      cycle();
    end

    // Well-behaved requesters: hold until ACK, measure waiting time.
    rst_n = 1'b1;
    req   = '0;
    cycle();
    cycle();
    for (int c = 0; c < 4000; c++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (req[i]) wc[i]++;
        if (ack[i]) begin
          chk("starve", wc[i] <= 3*N, 1);
          wc[i] = 0;
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else set_slice(i, W'($urandom));
        end else if (req[i] && wc[i] > 3*N) begin
          chk("starve_open", wc[i], 3*N);
          wc[i] = 0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          set_slice(i, W'($urandom));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters sharing the register (2..8).
REQ-002 Parameter W, default 8, register/data width in bits.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 REQ  input  N  per-requester write request; bit i belongs to requester i.
REQ-006 WDATA  input  N*W  packed write data; slice i = bits [i*W+W-1 : i*W].
REQ-007 GNT  output  N  one-hot grant, registered.
REQ-008 ACK  output  N  one-hot, one-cycle write-done pulse, registered.
REQ-009 Q  output  W  shared register contents.
REQ-010 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-011 The block SHALL implement FSM states IDLE, GRANT, ACK; one write per 3 cycles at most.
REQ-012 IDLE: if REQ != 0 at the edge, the block SHALL latch winner index idx, set GNT[idx] and go to GRANT; otherwise stay in IDLE with GNT=0.
REQ-013 Winner selection SHALL be round-robin: first set REQ bit searching from ptr upward, wrapping from N-1 to 0.
REQ-014 GRANT: if REQ[idx]=1 at the edge, Q SHALL load WDATA slice idx, ACK[idx] SHALL assert, and state SHALL go to ACK.
REQ-015 GRANT: if REQ[idx]=0 at the edge (abort), the block SHALL go to IDLE, clear GNT, leave Q and ptr unchanged, and assert no ACK.
REQ-016 ACK: the block SHALL unconditionally go to IDLE, clear GNT and ACK, and set ptr = (idx+1) mod N.
REQ-017 GNT SHALL be held during GRANT and ACK; GNT and ACK SHALL never have more than one bit set.
REQ-018 Latency: REQ set before edge k -> GNT visible after edge k, Q updated and ACK pulse after edge k+1, BUSY low after edge k+2.
REQ-019 Requesters SHALL hold REQ and WDATA stable until ACK; REQ still high in IDLE after ACK competes again at lowest priority.
REQ-020 REQ changes on non-winning bits during GRANT/ACK SHALL be ignored until the next IDLE.
REQ-021 Q SHALL change only on the GRANT->ACK transition.

Reset
REQ-022 While RST_N=0 at an edge: state=IDLE, ptr=0, GNT=0, ACK=0, Q=0, BUSY=0.
REQ-023 Reset asserted in GRANT or ACK SHALL abort the transfer with no ACK pulse emitted afterwards.
REQ-024 The first edge with RST_N=1 SHALL be evaluated as IDLE with ptr=0.

Structure
REQ-025 A shared package SHALL hold the state encoding (IDLE=2'b00, GRANT=2'b01, ACK=2'b10) and default N/W constants.
REQ-026 Round-robin selection SHALL be a separate combinational sub-module rr_priority_pick (inputs REQ, ptr; outputs found, idx).
REQ-027 All state (FSM, ptr, idx, GNT, ACK, Q) SHALL be flops on CLK only, no latches, no gated clocks.

Verification
REQ-028 Reset, then REQ=4'b0001, slice0=8'hA5 -> GNT=0001 after edge 1, Q=8'hA5 and ACK=0001 after edge 2, BUSY=0 after edge 3.
REQ-029 REQ=4'b1111 held with distinct data -> grant order 0,1,2,3,0; each ACK one cycle; Q tracks winner data.
REQ-030 REQ=4'b0100 granted, REQ[2] dropped in GRANT -> IDLE, Q unchanged, no ACK; next REQ=4'b0110 grants 1 (ptr still 0).
REQ-031 RST_N=0 during GRANT with REQ=4'b0010 -> next cycle GNT=0, ACK=0, Q=0, BUSY=0.
REQ-032 After requester 3 served, REQ=4'b1001 -> ptr wraps to 0, requester 0 granted.
REQ-033 Random REQ/WDATA for 10k cycles -> assertions: GNT/ACK one-hot-or-zero, ACK only after GRANT with REQ held, no starvation beyond 3*N cycles.
